dcache_mem_wr_arb: RTL

Write-channel arbiter between the DRAM cache controller and the memory controller. It shares the single memory-side AW/W/B port between two requesters: port 0 carries fill writes (tag+data installed after a miss) and port 1 carries write-hit updates. Each request is one bundle of ID, address and data. The block grants requesters round-robin, issues AW and W for the granted bundle, caps outstanding writes, and routes each B response back to the requester that owns it, in issue order.

---
 rtl/dcache_mem_wr_arb.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dcache_mem_wr_arb.sv
// Write-channel arbiter: shares the memory AW/W/B port round-robin between cache fill
// writes (port 0) and write-hit updates (port 1), routing each B back in issue order.
module dcache_mem_wr_arb #(
    parameter int ID_W    = 16,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s0_id_i,
    input  logic [ADDR_W-1:0] s0_addr_i,
    input  logic [DATA_W-1:0] s0_data_i,
    input  logic              s0_valid_i,
    output logic              s0_ready_o,
    output logic [ID_W-1:0]   s0_bid_o,
    output logic              s0_bvalid_o,
    input  logic              s0_bready_i,
    input  logic [ID_W-1:0]   s1_id_i,
    input  logic [ADDR_W-1:0] s1_addr_i,
    input  logic [DATA_W-1:0] s1_data_i,
    input  logic              s1_valid_i,
    output logic              s1_ready_o,
    output logic [ID_W-1:0]   s1_bid_o,
    output logic              s1_bvalid_o,
    input  logic              s1_bready_i,
    output logic [ID_W-1:0]   m_awid_o,
    output logic [ADDR_W-1:0] m_awaddr_o,
    output logic              m_awvalid_o,
    input  logic              m_awready_i,
    output logic [ID_W-1:0]   m_wid_o,
    output logic [DATA_W-1:0] m_wdata_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,
    input  logic [ID_W-1:0]   m_bid_i,
    input  logic              m_bvalid_i,
    output logic              m_bready_o,
    output logic              unexp_b_o
);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_e;

    state_e             state_q;
    logic               rr_ptr_q;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [MAX_OUT-1:0] fifo_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic               awvalid_q, wvalid_q, unexp_q;
    logic [ID_W-1:0]    id_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;

    logic can_grant_s, gnt0_s, gnt1_s, gnt_s;
    logic fifo_empty_s, head_s, b_hs_s, aw_done_s, w_done_s;

    // Grant decision, B routing by FIFO head and next outstanding count
    always_comb begin
        can_grant_s  = (state_q == IDLE) && (out_cnt_q < MAX_CNT);
        gnt0_s       = can_grant_s && s0_valid_i && (!s1_valid_i || (rr_ptr_q == 1'b0));
        gnt1_s       = can_grant_s && s1_valid_i && (!s0_valid_i || (rr_ptr_q == 1'b1));
        gnt_s        = gnt0_s || gnt1_s;
        fifo_empty_s = (out_cnt_q == {CNT_W{1'b0}});
        head_s       = fifo_q[rd_ptr_q];
        s0_bvalid_o  = 1'b0;
        s1_bvalid_o  = 1'b0;
        s0_bid_o     = {ID_W{1'b0}};
        s1_bid_o     = {ID_W{1'b0}};
        m_bready_o   = 1'b1;
        if (fifo_empty_s) begin
            m_bready_o = 1'b1;
        end else if (head_s) begin
            s1_bvalid_o = m_bvalid_i;
            s1_bid_o    = m_bid_i;
            m_bready_o  = s1_bready_i;
        end else begin
            s0_bvalid_o = m_bvalid_i;
            s0_bid_o    = m_bid_i;
            m_bready_o  = s0_bready_i;
        end
        b_hs_s    = m_bvalid_i && m_bready_o && !fifo_empty_s;
        out_cnt_d = out_cnt_q + {{(CNT_W-1){1'b0}}, gnt_s} - {{(CNT_W-1){1'b0}}, b_hs_s};
        aw_done_s = !awvalid_q || m_awready_i;
        w_done_s  = !wvalid_q || m_wready_i;
    end

    assign s0_ready_o  = gnt0_s;
    assign s1_ready_o  = gnt1_s;
    assign m_awid_o    = id_q;
    assign m_awaddr_o  = addr_q;
    assign m_awvalid_o = awvalid_q;
    assign m_wid_o     = id_q;
    assign m_wdata_o   = data_q;
    assign m_wvalid_o  = wvalid_q;
    assign unexp_b_o   = unexp_q;

    // Arbiter FSM with latched bundle, owner-order FIFO and sticky unexpected-B flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            out_cnt_q <= {CNT_W{1'b0}};
            fifo_q    <= {MAX_OUT{1'b0}};
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            unexp_q   <= 1'b0;
            id_q      <= {ID_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            data_q    <= {DATA_W{1'b0}};
        end else begin
            out_cnt_q <= out_cnt_d;
            if (b_hs_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (fifo_empty_s && m_bvalid_i) begin
                unexp_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (gnt_s) begin
                        id_q             <= gnt1_s ? s1_id_i : s0_id_i;
                        addr_q           <= gnt1_s ? s1_addr_i : s0_addr_i;
                        data_q           <= gnt1_s ? s1_data_i : s0_data_i;
                        fifo_q[wr_ptr_q] <= gnt1_s;
                        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
                        rr_ptr_q         <= ~gnt1_s;
                        awvalid_q        <= 1'b1;
                        wvalid_q         <= 1'b1;
                        state_q          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_awready_i) begin
                        awvalid_q <= 1'b0;
                    end
                    if (m_wready_i) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done_s && w_done_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
